// File: rtl/load_store_monitor.sv
// load_store_monitor: checks period, lock and high-run health of a pulse stream
module load_store_monitor #(
  parameter int PERIOD   = 5000,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 2,
  parameter int MAXHI    = 2,
  parameter int CBITS    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             sig_in,
  output logic             locked,
  output logic             err,
  output logic [CBITS-1:0] period_out,
  output logic [7:0]       edges
);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, FAULT} state_t;
  localparam int HW = $clog2(MAXHI + 2);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] CMAX = '1;
  localparam logic [CBITS-1:0] LO = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] HI = CBITS'(PERIOD + TOL);
  state_t state, state_n;
  logic prev, rise, in_range, timeout, hi_fault;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [HW-1:0] hi_run;
  logic [GW-1:0] good, good_n;
  assign rise     = sig_in & ~prev;
  assign in_range = cnt >= LO && cnt <= HI;
  assign timeout  = !rise && cnt > HI;
  assign hi_fault = sig_in && hi_run == HW'(MAXHI);
  assign locked   = state == LOCKED;
  assign err      = state == FAULT;
  // next state, good-period count and gap counter; clr wins over every transition
  always_comb begin
    state_n = state;
    good_n  = good;
    if (clr) begin
      state_n = IDLE;
      good_n  = '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state_n = ARMED;
          good_n  = '0;
        end
        ARMED: if (rise) begin
          good_n = in_range ? good + 1'b1 : '0;
          if (in_range && good == GW'(LOCK_CNT - 1)) state_n = LOCKED;
        end else if (timeout) state_n = IDLE;
        LOCKED: if ((rise && !in_range) || timeout || hi_fault) state_n = FAULT;
        default: ;
      endcase
    end
    cnt_n = state_n == IDLE ? '0 : rise ? CBITS'(1) : cnt == CMAX ? cnt : cnt + 1'b1;
  end
  // all state advances only on enabled samples; disabled cycles are invisible
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= 1'b0;
      cnt        <= '0;
      hi_run     <= '0;
      good       <= '0;
      period_out <= '0;
      edges      <= '0;
    end else if (en) begin
      state  <= state_n;
      prev   <= sig_in;
      cnt    <= cnt_n;
      good   <= good_n;
      hi_run <= !sig_in ? '0 : hi_run == HW'(MAXHI + 1) ? hi_run : hi_run + 1'b1;
      if (rise && state != IDLE) period_out <= cnt;
      if (rise && edges != 8'hff) edges <= edges + 1'b1;
    end
  end
endmodule

// File: tb/tb_load_store_monitor.sv
// tb_load_store_monitor: randomized pulse streams checked against a timestamp-based reference model
module tb_load_store_monitor;
  localparam int P = 10, T = 1, LC = 2, MH = 2, CB = 8;
  logic clk = 0, rst = 1, en = 0, clr = 0, sig_in = 0;
  logic locked, err;
  logic [CB-1:0] period_out;
  logic [7:0] edges;
  load_store_monitor #(.PERIOD(P), .TOL(T), .LOCK_CNT(LC), .MAXHI(MH), .CBITS(CB)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sig_in(sig_in),
    .locked(locked), .err(err), .period_out(period_out), .edges(edges)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       lk;
    logic       er;
    logic [7:0] per;
    logic [7:0] edg;
  } exp_t;
  exp_t q[$];
  exp_t x;
  int checks = 0, passed = 0, cyc_no = 0;
  typedef enum {M_IDLE, M_ARMED, M_LOCKED, M_FAULT} mst_t;
  mst_t m_st = M_IDLE;
  int n = 0, last_rise = 0, last_low = -1, m_good = 0, m_period = 0, m_edges = 0;
  bit m_prev = 0;
  task automatic model(input bit r, input bit e, input bit c, input bit s);
    bit rise, ok, tmo;
    int d, hrun;
    if (r) begin
      m_st = M_IDLE; m_prev = 0; m_good = 0; m_period = 0; m_edges = 0; last_low = n - 1;
    end else if (e) begin
      rise = s && !m_prev;
      d = n - last_rise;
      if (d > 255) d = 255;
      hrun = (n - 1) - last_low;
      ok = d >= P - T && d <= P + T;
      tmo = !rise && d >= P + T + 1;
      if (rise && m_edges < 255) m_edges++;
      if (rise && m_st != M_IDLE) m_period = d;
      if (c) begin
        m_st = M_IDLE; m_good = 0;
      end else if (m_st == M_IDLE) begin
        if (rise) begin m_st = M_ARMED; m_good = 0; end
      end else if (m_st == M_ARMED) begin
        if (rise) begin
          m_good = ok ? m_good + 1 : 0;
          if (m_good == LC) m_st = M_LOCKED;
        end else if (tmo) m_st = M_IDLE;
      end else if (m_st == M_LOCKED) begin
        if ((rise && !ok) || tmo || (s && hrun == MH)) m_st = M_FAULT;
      end
      if (rise) last_rise = n;
      if (!s) last_low = n;
      m_prev = s;
      n++;
    end
    q.push_back({m_st == M_LOCKED, m_st == M_FAULT, 8'(m_period), 8'(m_edges)});
  endtask
  task automatic cyc(input bit r, input bit e, input bit c, input bit s);
    @(negedge clk);
    rst = r; en = e; clr = c; sig_in = s;
    model(r, e, c, s);
  endtask
  task automatic sample(input bit s, input bit c);
    if ($urandom_range(0, 149) == 0)
      repeat (50) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while ($urandom_range(0, 14) == 0) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    cyc($urandom_range(0, 999) == 0, 1'b1, c || $urandom_range(0, 299) == 0, s);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      cyc_no++;
      if (locked === x.lk && err === x.er && period_out === x.per && edges === x.edg) passed++;
      else $display("FAIL outputs cycle %0d: got locked=%0b err=%0b period=%0d edges=%0d, expected locked=%0b err=%0b period=%0d edges=%0d",
                    cyc_no, locked, err, period_out, edges, x.lk, x.er, x.per, x.edg);
    end
  end
  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish in time");
    $finish;
  end
  int gaps[14] = '{10, 10, 10, 10, 10, 9, 11, 9, 11, 12, 8, 13, 25, 300};
  int wids[6] = '{1, 1, 1, 1, 2, 3};
  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (locked === 1'b0 && err === 1'b0 && period_out === '0 && edges === 8'd0) passed++;
    else $display("FAIL reset state: locked=%0b err=%0b period=%0d edges=%0d", locked, err, period_out, edges);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 220; p++) begin
      int g, w;
      bit c;
      g = gaps[$urandom_range(0, 13)];
      w = wids[$urandom_range(0, 5)];
      c = m_st == M_FAULT && $urandom_range(0, 2) == 0;
      for (int i = 0; i < g; i++) sample(i < w, c && i == 0);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
